maze_store: RTL

Grid storage and responder for the maze solver. It holds a (2^maze_width) x (2^maze_width) cell map, loaded serially after reset. In service it answers the solver's row/col read requests on `maze_in` with one cycle of latency and applies its visited-cell marks on `maze_we`. It sits between the maze loader (testbench or host) and the solver FSM.

---
 rtl/maze_pkg.sv | 20 ++
 rtl/maze_cell_ram.sv | 19 +
 rtl/maze_store.sv | 111 +++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared cell codes, FSM encoding and grid sizing for the maze store.
package maze_pkg;
  localparam int MAZE_WIDTH = 6;
  localparam int GRID_CELLS = 2 ** (2 * MAZE_WIDTH);

  typedef enum logic [1:0] {
    FREE    = 2'b00,
    WALL    = 2'b01,
    VISITED = 2'b10
  } cell_t;

  typedef enum logic {
    LOAD  = 1'b0,
    SERVE = 1'b1
  } state_t;

  function automatic int grid_cells(input int w);
    return 2 ** (2 * w);
  endfunction
endpackage

// File: rtl/maze_cell_ram.sv
// 2-bit cell RAM: one synchronous read port, one write port, read-before-write.
module maze_cell_ram #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] raddr,
  output logic [1:0]    rdata,
  input  logic          wr_en,
  input  logic [AW-1:0] waddr,
  input  logic [1:0]    wdata
);
  logic [1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (rd_en) rdata <= mem[raddr];
    if (wr_en) mem[waddr] <= wdata;
  end
endmodule

// File: rtl/maze_store.sv
// Maze grid store: serial load, 1-cycle reads, visited marking with wall protect.
// MAZE_VISIT_CNT_EN adds the visit_count port and first-visit counter.
module maze_store
  import maze_pkg::*;
#(
  parameter int maze_width = MAZE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [maze_width-1:0] row,
  input  logic [maze_width-1:0] col,
  input  logic                  maze_oe,
  input  logic                  maze_we,
  output logic                  maze_in,
  input  logic                  load_valid,
  input  logic                  load_wall,
  output logic                  load_ready,
  input  logic                  load_start,
  output logic                  load_done
`ifdef MAZE_VISIT_CNT_EN
  ,
  output logic [2*maze_width:0] visit_count
`endif
);
  localparam int AW = 2 * maze_width;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, addr, pend_addr_q, waddr;
  logic          beat, serve_go, rd_en, wr_en, commit;
  logic          pend_q, fwd_hit_q, last_oe_q, hold_q;
  logic [1:0]    rdata, wdata;
  cell_t         eff;

  assign addr     = {row, col};
  assign serve_go = (state_q == SERVE) && !load_start;
  assign rd_en    = serve_go && (maze_oe || maze_we);

  // Marks are committed one cycle after maze_we, once the old cell is known;
  // a read that lands on the cell being committed sees VISITED via fwd_hit_q.
  assign eff = fwd_hit_q ? VISITED : cell_t'(rdata);

`ifdef MAZE_VISIT_CNT_EN
  assign commit = pend_q && (eff == FREE);
`else
  assign commit = pend_q && (eff != WALL);
`endif

  assign wr_en = beat || commit;
  assign waddr = (state_q == LOAD) ? cnt_q : pend_addr_q;
  assign wdata = (state_q == LOAD) ? (load_wall ? WALL : FREE) : VISITED;

  assign maze_in = last_oe_q ? (eff == WALL) : hold_q;

  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    load_done  = 1'b0;
    beat       = 1'b0;
    case (state_q)
      LOAD: begin
        load_ready = 1'b1;
        beat       = load_valid && !load_start;
        if (beat && cnt_q == '1) state_d = SERVE;
      end
      SERVE: begin
        load_done = 1'b1;
        if (load_start) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      fwd_hit_q   <= 1'b0;
      last_oe_q   <= 1'b0;
      hold_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_start)  cnt_q <= '0;
      else if (beat)   cnt_q <= cnt_q + AW'(1);
      pend_q      <= serve_go && maze_we;
      pend_addr_q <= addr;
      if (!serve_go)  fwd_hit_q <= 1'b0;
      else if (rd_en) fwd_hit_q <= commit && (pend_addr_q == addr);
      last_oe_q <= serve_go && maze_oe;
      hold_q    <= serve_go ? maze_in : 1'b0;
    end
  end

`ifdef MAZE_VISIT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || load_start) visit_count <= '0;
    else if (commit)       visit_count <= visit_count + (2*maze_width+1)'(1);
  end
`endif

  maze_cell_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .rd_en (rd_en),
    .raddr (addr),
    .rdata (rdata),
    .wr_en (wr_en),
    .waddr (waddr),
    .wdata (wdata)
  );
endmodule
